// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings,
// the op typedef and the legal-width helper.
package bshift_pkg;

    typedef logic [2:0] bshift_op_t;

    localparam bshift_op_t OP_SLL = 3'b000;
    localparam bshift_op_t OP_SRL = 3'b001;
    localparam bshift_op_t OP_SRA = 3'b010;
    localparam bshift_op_t OP_ROL = 3'b011;
    localparam bshift_op_t OP_ROR = 3'b100;

    // Data width must be a power of two and at least 4 bits.
    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/bshift_stage.sv
// One pipeline stage of the barrel shifter: conditional shift/rotate by 2^STAGE
// plus its register. Carry tracking is present only when BSHIFT_CARRY_EN is defined.
module bshift_stage
    import bshift_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int STAGE = 0,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_amt,
    input  bshift_op_t       prev_op,
`ifdef BSHIFT_CARRY_EN
    input  logic             prev_carry,
    output logic             carry,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   amt,
    output bshift_op_t       op
);

    localparam int SH = 1 << STAGE;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = prev_data;
        if (prev_amt[STAGE]) begin
            case (prev_op)
                OP_SLL:  shifted = prev_data << SH;
                OP_SRL:  shifted = prev_data >> SH;
                OP_SRA:  shifted = WIDTH'($signed(prev_data) >>> SH);
                OP_ROL:  shifted = (prev_data << SH) | (prev_data >> (WIDTH - SH));
                OP_ROR:  shifted = (prev_data >> SH) | (prev_data << (WIDTH - SH));
                default: shifted = prev_data;
            endcase
        end
    end

`ifdef BSHIFT_CARRY_EN
    // The last bit leaving the word is whatever the most recent active stage dropped.
    logic left_out;
    logic right_out;
    logic carry_next;

    assign left_out  = prev_data[WIDTH-SH];
    assign right_out = prev_data[SH-1];

    always_comb begin
        carry_next = prev_carry;
        if (prev_amt[STAGE]) begin
            case (prev_op)
                OP_SLL, OP_ROL:         carry_next = left_out;
                OP_SRL, OP_SRA, OP_ROR: carry_next = right_out;
                default:                carry_next = prev_carry;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (advance) begin
            carry <= carry_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            op    <= OP_SLL;
        end else if (advance) begin
            valid <= prev_valid;
            data  <= shifted;
            amt   <= prev_amt;
            op    <= prev_op;
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter, one power-of-two per registered stage, latency log2(WIDTH).
// Define BSHIFT_CARRY_EN to add the out_carry port and its pipelined carry path.
module pipe_barrel_shifter
    import bshift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
`ifdef BSHIFT_CARRY_EN
    output logic             out_carry,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("pipe_barrel_shifter: WIDTH must be a power of two and >= 4");
    end

    logic                        advance;
    logic [SHW:0]                valid_pipe;
    logic [SHW:0][WIDTH-1:0]     data_pipe;
    logic [SHW:0][SHW-1:0]       amt_pipe;
    bshift_op_t [SHW:0]          op_pipe;
    logic                        unused_tail;

    // Whole pipe moves or holds together, so bubbles never get squeezed out.
    assign advance  = !valid_pipe[SHW] || out_ready;
    assign in_ready = advance;

    assign valid_pipe[0] = in_valid;
    assign data_pipe[0]  = in_data;
    assign amt_pipe[0]   = in_amt;
    assign op_pipe[0]    = in_op;

`ifdef BSHIFT_CARRY_EN
    logic [SHW:0] carry_pipe;
    assign carry_pipe[0] = 1'b0;
    assign out_carry     = carry_pipe[SHW];
`endif

    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        bshift_stage #(
            .WIDTH (WIDTH),
            .STAGE (gi)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .advance    (advance),
            .prev_valid (valid_pipe[gi]),
            .prev_data  (data_pipe[gi]),
            .prev_amt   (amt_pipe[gi]),
            .prev_op    (op_pipe[gi]),
`ifdef BSHIFT_CARRY_EN
            .prev_carry (carry_pipe[gi]),
            .carry      (carry_pipe[gi+1]),
`endif
            .valid      (valid_pipe[gi+1]),
            .data       (data_pipe[gi+1]),
            .amt        (amt_pipe[gi+1]),
            .op         (op_pipe[gi+1])
        );
    end

    assign out_valid = valid_pipe[SHW];
    assign out_data  = data_pipe[SHW];

    // Amount/op have no consumer after the final stage.
    assign unused_tail = ^{amt_pipe[SHW], op_pipe[SHW]};

endmodule
